// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcode encodings, arbiter FSM states and
// the size-to-beat-count helper used by burst locking.
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } d_opcode_e;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  localparam int unsigned MAX_SIZE = 12;

  // Number of data beats a transfer of 2^size bytes occupies on a dw-bit bus.
  // Illegal sizes (> 4 KiB) collapse to a single beat so they never lock.
  function automatic int unsigned beat_count(input int unsigned size, input int unsigned dw);
    int unsigned bytes_per_beat;
    bytes_per_beat = dw / 8;
    if (size > MAX_SIZE || (32'd1 << size) <= bytes_per_beat) return 1;
    return (32'd1 << size) / bytes_per_beat;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// M-wide round-robin picker: scans upward from last_grant+1 with wrap, or
// forces lock_id while a burst holds the lock.
module tl_rr_arbiter #(
  parameter int M  = 2,
  parameter int MW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [MW-1:0] last_grant,
  input  logic          lock,
  input  logic [MW-1:0] lock_id,
  output logic [MW-1:0] grant,
  output logic          grant_valid
);

  int cand;

  // NOTE: every output gets a default before the conditional logic so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    grant       = lock_id;
    grant_valid = lock;
    cand        = 0;
    if (!lock) begin
      for (int k = 1; k <= M; k++) begin
        cand = (int'(last_grant) + k) % M;
        if (!grant_valid && req[cand]) begin
          grant       = MW'(cand);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tilelink_nto1_arbiter.sv
// N-to-1 TileLink-UL arbiter: round-robin A channel with Put-burst locking and
// a registered output stage; D responses are steered by the prepended index.
module tilelink_nto1_arbiter
  import tl_pkg::*;
#(
  parameter int M     = 2,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
) (
  input  logic                      tilelink_clock_i,
  input  logic                      tilelink_reset_ni,
  input  logic [3*M-1:0]            master_a_opcode,
  input  logic [3*M-1:0]            master_a_param,
  input  logic [M*TL_SZ-1:0]        master_a_size,
  input  logic [M*TL_RS-1:0]        master_a_source,
  input  logic [M*TL_AW-1:0]        master_a_address,
  input  logic [M*TL_DW/8-1:0]      master_a_mask,
  input  logic [M*TL_DW-1:0]        master_a_data,
  input  logic [M-1:0]              master_a_corrupt,
  input  logic [M-1:0]              master_a_valid,
  output logic [M-1:0]              master_a_ready,
  output logic [3*M-1:0]            master_d_opcode,
  output logic [2*M-1:0]            master_d_param,
  output logic [M*TL_SZ-1:0]        master_d_size,
  output logic [M*TL_RS-1:0]        master_d_source,
  output logic [M-1:0]              master_d_denied,
  output logic [M-1:0]              master_d_corrupt,
  output logic [M-1:0]              master_d_valid,
  output logic [M*TL_DW-1:0]        master_d_data,
  input  logic [M-1:0]              master_d_ready,
  output logic [2:0]                slave_a_opcode,
  output logic [2:0]                slave_a_param,
  output logic [TL_SZ-1:0]          slave_a_size,
  output logic [TL_RS+$clog2(M)-1:0] slave_a_source,
  output logic [TL_AW-1:0]          slave_a_address,
  output logic [TL_DW/8-1:0]        slave_a_mask,
  output logic [TL_DW-1:0]          slave_a_data,
  output logic                      slave_a_corrupt,
  output logic                      slave_a_valid,
  input  logic                      slave_a_ready,
  input  logic [2:0]                slave_d_opcode,
  input  logic [1:0]                slave_d_param,
  input  logic [TL_SZ-1:0]          slave_d_size,
  input  logic [TL_RS+$clog2(M)-1:0] slave_d_source,
  input  logic                      slave_d_denied,
  input  logic                      slave_d_corrupt,
  input  logic                      slave_d_valid,
  input  logic [TL_DW-1:0]          slave_d_data,
  output logic                      slave_d_ready,
  output logic                      decode_error_o
);

  localparam int MW = $clog2(M);
  localparam int SW = TL_RS + MW;
  localparam int BW = TL_DW / 8;

  arb_state_e    state, state_next;
  logic [11:0]   beats_left, beats_left_next;
  logic [MW-1:0] lock_id, lock_id_next;
  logic [MW-1:0] last_grant, last_grant_next;
  logic [MW-1:0] grant;
  logic          grant_valid, stage_free, accept, is_burst, d_hit;
  int unsigned   sel_beats;

  logic [2:0]       sel_opcode, sel_param;
  logic [TL_SZ-1:0] sel_size;
  logic [TL_RS-1:0] sel_source;
  logic [TL_AW-1:0] sel_address;
  logic [BW-1:0]    sel_mask;
  logic [TL_DW-1:0] sel_data;
  logic             sel_corrupt, sel_valid;

  tl_rr_arbiter #(.M(M), .MW(MW)) u_rr (
    .req        (master_a_valid),
    .last_grant (last_grant),
    .lock       (state == BURST),
    .lock_id    (lock_id),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  assign stage_free = !slave_a_valid || slave_a_ready;

  always_comb begin
    master_a_ready = '0;
    sel_opcode = '0; sel_param = '0; sel_size = '0; sel_source = '0;
    sel_address = '0; sel_mask = '0; sel_data = '0; sel_corrupt = 1'b0; sel_valid = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (grant == MW'(i)) begin
        master_a_ready[i] = grant_valid && stage_free;
        sel_opcode  = master_a_opcode[3*i +: 3];
        sel_param   = master_a_param[3*i +: 3];
        sel_size    = master_a_size[TL_SZ*i +: TL_SZ];
        sel_source  = master_a_source[TL_RS*i +: TL_RS];
        sel_address = master_a_address[TL_AW*i +: TL_AW];
        sel_mask    = master_a_mask[BW*i +: BW];
        sel_data    = master_a_data[TL_DW*i +: TL_DW];
        sel_corrupt = master_a_corrupt[i];
        sel_valid   = master_a_valid[i];
      end
    end
  end

  assign accept    = grant_valid && stage_free && sel_valid;
  assign sel_beats = beat_count(32'(sel_size), TL_DW);
  assign is_burst  = (sel_opcode == PUT_FULL || sel_opcode == PUT_PARTIAL) && sel_beats > 1;

  always_comb begin
    state_next      = state;
    beats_left_next = beats_left;
    lock_id_next    = lock_id;
    last_grant_next = last_grant;
    if (accept) begin
      case (state)
        IDLE: begin
          if (is_burst) begin
            beats_left_next = 12'(sel_beats - 1);
            lock_id_next    = grant;
            state_next      = BURST;
          end else begin
            last_grant_next = grant;
          end
        end
        BURST: begin
          beats_left_next = beats_left - 12'd1;
          if (beats_left == 12'd1) begin
            state_next      = IDLE;
            last_grant_next = lock_id;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
    if (!tilelink_reset_ni) begin
      state      <= IDLE;
      beats_left <= '0;
      lock_id    <= '0;
      last_grant <= MW'(M - 1);
      slave_a_valid <= 1'b0;
    end else begin
      state      <= state_next;
      beats_left <= beats_left_next;
      lock_id    <= lock_id_next;
      last_grant <= last_grant_next;
      if (accept)             slave_a_valid <= 1'b1;
      else if (slave_a_ready) slave_a_valid <= 1'b0;
    end
  end

  // NOTE: the payload register is qualified by slave_a_valid, so it needs no
  // reset; leaving it out keeps reset fan-out off the wide datapath.
  always_ff @(posedge tilelink_clock_i) begin
    if (accept) begin
      slave_a_opcode  <= sel_opcode;
      slave_a_param   <= sel_param;
      slave_a_size    <= sel_size;
      slave_a_source  <= {grant, sel_source};
      slave_a_address <= sel_address;
      slave_a_mask    <= sel_mask;
      slave_a_data    <= sel_data;
      slave_a_corrupt <= sel_corrupt;
    end
  end

  // D channel: pure steering; an index with no master is sunk and flagged.
  always_comb begin
    master_d_valid = '0;
    slave_d_ready  = 1'b1;
    d_hit          = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (slave_d_source[SW-1:TL_RS] == MW'(i)) begin
        master_d_valid[i] = slave_d_valid;
        slave_d_ready     = master_d_ready[i];
        d_hit             = 1'b1;
      end
    end
  end

  assign master_d_opcode  = {M{slave_d_opcode}};
  assign master_d_param   = {M{slave_d_param}};
  assign master_d_size    = {M{slave_d_size}};
  assign master_d_source  = {M{slave_d_source[TL_RS-1:0]}};
  assign master_d_denied  = {M{slave_d_denied}};
  assign master_d_corrupt = {M{slave_d_corrupt}};
  assign master_d_data    = {M{slave_d_data}};

  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
    if (!tilelink_reset_ni) decode_error_o <= 1'b0;
    else                    decode_error_o <= slave_d_valid && !d_hit;
  end

endmodule

// File: tb/tb_tilelink_nto1_arbiter.sv
// Bench for tilelink_nto1_arbiter: directed protocol steps on an M=2 and an
// M=3 instance, then random traffic against a transaction-order model.
module tb_tilelink_nto1_arbiter;
  import tl_pkg::*;

  localparam int M = 2, DW = 32, AW = 32, RS = 4, SZ = 4, SW = RS + 1;

  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // M=2 instance signals
  logic [3*M-1:0] a_opcode, a_param;
  logic [M*SZ-1:0] a_size;
  logic [M*RS-1:0] a_source;
  logic [M*AW-1:0] a_address;
  logic [M*DW/8-1:0] a_mask;
  logic [M*DW-1:0] a_data;
  logic [M-1:0] a_corrupt, a_valid, a_ready;
  logic [3*M-1:0] d_opcode;
  logic [2*M-1:0] d_param;
  logic [M*SZ-1:0] d_size;
  logic [M*RS-1:0] d_source;
  logic [M-1:0] d_denied, d_corrupt, d_valid, d_ready;
  logic [M*DW-1:0] d_data;
  logic [2:0] sa_opcode, sa_param;
  logic [SZ-1:0] sa_size;
  logic [SW-1:0] sa_source;
  logic [AW-1:0] sa_address;
  logic [DW/8-1:0] sa_mask;
  logic [DW-1:0] sa_data;
  logic sa_corrupt, sa_valid, sa_ready;
  logic [2:0] sd_opcode;
  logic [1:0] sd_param;
  logic [SZ-1:0] sd_size;
  logic [SW-1:0] sd_source;
  logic sd_denied, sd_corrupt, sd_valid, sd_ready;
  logic [DW-1:0] sd_data;
  logic dec_err;

  tilelink_nto1_arbiter #(.M(M), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut (
    .tilelink_clock_i(clk), .tilelink_reset_ni(rst_n),
    .master_a_opcode(a_opcode), .master_a_param(a_param), .master_a_size(a_size),
    .master_a_source(a_source), .master_a_address(a_address), .master_a_mask(a_mask),
    .master_a_data(a_data), .master_a_corrupt(a_corrupt), .master_a_valid(a_valid),
    .master_a_ready(a_ready),
    .master_d_opcode(d_opcode), .master_d_param(d_param), .master_d_size(d_size),
    .master_d_source(d_source), .master_d_denied(d_denied), .master_d_corrupt(d_corrupt),
    .master_d_valid(d_valid), .master_d_data(d_data), .master_d_ready(d_ready),
    .slave_a_opcode(sa_opcode), .slave_a_param(sa_param), .slave_a_size(sa_size),
    .slave_a_source(sa_source), .slave_a_address(sa_address), .slave_a_mask(sa_mask),
    .slave_a_data(sa_data), .slave_a_corrupt(sa_corrupt), .slave_a_valid(sa_valid),
    .slave_a_ready(sa_ready),
    .slave_d_opcode(sd_opcode), .slave_d_param(sd_param), .slave_d_size(sd_size),
    .slave_d_source(sd_source), .slave_d_denied(sd_denied), .slave_d_corrupt(sd_corrupt),
    .slave_d_valid(sd_valid), .slave_d_data(sd_data), .slave_d_ready(sd_ready),
    .decode_error_o(dec_err)
  );

  // M=3 instance: only the D channel is exercised
  logic [2:0] x3_a_ready, x3_d_denied, x3_d_corrupt, x3_d_valid, x3_d_ready;
  logic [8:0] x3_d_opcode;
  logic [5:0] x3_d_param;
  logic [11:0] x3_d_size, x3_d_source;
  logic [95:0] x3_d_data;
  logic [2:0] x3_sa_opcode, x3_sa_param;
  logic [3:0] x3_sa_size, x3_sa_mask;
  logic [5:0] x3_sa_source, x3_sd_source;
  logic [31:0] x3_sa_address, x3_sa_data;
  logic x3_sa_corrupt, x3_sa_valid, x3_sd_valid, x3_sd_ready, x3_dec_err;

  tilelink_nto1_arbiter #(.M(3), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut3 (
    .tilelink_clock_i(clk), .tilelink_reset_ni(rst_n),
    .master_a_opcode(9'd0), .master_a_param(9'd0), .master_a_size(12'd0),
    .master_a_source(12'd0), .master_a_address(96'd0), .master_a_mask(12'd0),
    .master_a_data(96'd0), .master_a_corrupt(3'd0), .master_a_valid(3'd0),
    .master_a_ready(x3_a_ready),
    .master_d_opcode(x3_d_opcode), .master_d_param(x3_d_param), .master_d_size(x3_d_size),
    .master_d_source(x3_d_source), .master_d_denied(x3_d_denied), .master_d_corrupt(x3_d_corrupt),
    .master_d_valid(x3_d_valid), .master_d_data(x3_d_data), .master_d_ready(x3_d_ready),
    .slave_a_opcode(x3_sa_opcode), .slave_a_param(x3_sa_param), .slave_a_size(x3_sa_size),
    .slave_a_source(x3_sa_source), .slave_a_address(x3_sa_address), .slave_a_mask(x3_sa_mask),
    .slave_a_data(x3_sa_data), .slave_a_corrupt(x3_sa_corrupt), .slave_a_valid(x3_sa_valid),
    .slave_a_ready(1'b1),
    .slave_d_opcode(3'd0), .slave_d_param(2'd0), .slave_d_size(4'd2),
    .slave_d_source(x3_sd_source), .slave_d_denied(1'b0), .slave_d_corrupt(1'b0),
    .slave_d_valid(x3_sd_valid), .slave_d_data(32'h0), .slave_d_ready(x3_sd_ready),
    .decode_error_o(x3_dec_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [2:0] op, input logic [3:0] size,
                       input logic [3:0] src, input logic [31:0] addr,
                       input logic [31:0] data, input logic v);
    a_opcode[3*i +: 3]   = op;
    a_param[3*i +: 3]    = 3'd0;
    a_size[4*i +: 4]     = size;
    a_source[4*i +: 4]   = src;
    a_address[32*i +: 32] = addr;
    a_mask[4*i +: 4]     = 4'hf;
    a_data[32*i +: 32]   = data;
    a_corrupt[i]         = 1'b0;
    a_valid[i]           = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Random-phase model: per-master beat lists and the expected slave order.
  typedef struct packed {
    logic       m;
    logic [2:0] op;
    logic [3:0] size;
    logic [3:0] src;
    logic [31:0] addr;
    logic [31:0] data;
    logic       last;
  } beat_t;

  beat_t mb[2][128];
  int    mcnt[2], mptr[2];
  beat_t exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0;
    a_mask = '0; a_data = '0; a_corrupt = '0; a_valid = '0;
    d_ready = '0; sa_ready = 1'b1;
    sd_opcode = '0; sd_param = '0; sd_size = '0; sd_source = '0; sd_denied = 1'b0;
    sd_corrupt = 1'b0; sd_valid = 1'b0; sd_data = '0;
    x3_d_ready = '0; x3_sd_source = '0; x3_sd_valid = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_slave_a_valid", sa_valid, 0);
    check("reset_master_a_ready", a_ready, 0);
    check("reset_decode_error", dec_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two simultaneous Gets: master 0 first, then master 1.
    drive(0, GET, 4'd2, 4'h3, 32'h100, 32'h0, 1'b1);
    drive(1, GET, 4'd2, 4'h5, 32'h200, 32'h0, 1'b1);
    #1 check("rr_first_ready", a_ready, 2'b01);
    step(); drive(0, GET, 4'd2, 4'h3, 32'h100, 32'h0, 1'b0);
    #1 check("rr_src0", sa_source, 5'h03);
    check("rr_addr0", sa_address, 32'h100);
    check("rr_second_ready", a_ready, 2'b10);
    step(); drive(1, GET, 4'd2, 4'h5, 32'h200, 32'h0, 1'b0);
    #1 check("rr_src1", sa_source, 5'h15);
    check("rr_valid1", sa_valid, 1);

    // Next contest returns to master 0.
    drive(0, GET, 4'd2, 4'h9, 32'h300, 32'h0, 1'b1);
    drive(1, GET, 4'd2, 4'ha, 32'h400, 32'h0, 1'b1);
    #1 check("rr_again_ready", a_ready, 2'b01);
    step(); drive(0, GET, 4'd2, 4'h9, 32'h300, 32'h0, 1'b0);
    #1 check("rr_again_src0", sa_source, 5'h09);
    step(); drive(1, GET, 4'd2, 4'ha, 32'h400, 32'h0, 1'b0);
    #1 check("rr_again_src1", sa_source, 5'h1a);

    // Master 0 alone so master 1 holds priority for the burst.
    drive(0, GET, 4'd2, 4'h1, 32'h500, 32'h0, 1'b1);
    #1 check("solo_ready", a_ready, 2'b01);
    step(); drive(0, GET, 4'd2, 4'h1, 32'h500, 32'h0, 1'b0);
    #1 check("solo_src", sa_source, 5'h01);

    // 4-beat PutFull from master 1 while master 0 keeps requesting.
    drive(1, PUT_FULL, 4'd4, 4'h2, 32'h600, 32'hb000_0000, 1'b1);
    drive(0, GET, 4'd2, 4'hc, 32'h700, 32'h0, 1'b1);
    #1 check("burst_ready_b0", a_ready, 2'b10);
    for (int b = 1; b < 4; b++) begin
      step(); drive(1, PUT_FULL, 4'd4, 4'h2, 32'h600, 32'hb000_0000 + b, 1'b1);
      #1 check("burst_data", sa_data, 32'hb000_0000 + b - 1);
      check("burst_src", sa_source, 5'h12);
      check("burst_lock_ready", a_ready, 2'b10);
    end
    step(); drive(1, PUT_FULL, 4'd4, 4'h2, 32'h600, 32'h0, 1'b0);
    #1 check("burst_last_data", sa_data, 32'hb000_0003);
    check("after_burst_ready", a_ready, 2'b01);

    // Slave back-pressure for three cycles.
    step();
    sa_ready = 1'b0;
    drive(0, GET, 4'd2, 4'hc, 32'h700, 32'h0, 1'b0);
    drive(1, GET, 4'd2, 4'hd, 32'h800, 32'h0, 1'b1);
    #1 check("stall_src", sa_source, 5'h0c);
    check("stall_ready", a_ready, 2'b00);
    for (int s = 0; s < 2; s++) begin
      step();
      #1 check("stall_hold_src", sa_source, 5'h0c);
      check("stall_hold_addr", sa_address, 32'h700);
      check("stall_hold_valid", sa_valid, 1);
      check("stall_hold_ready", a_ready, 2'b00);
    end
    step(); sa_ready = 1'b1;
    #1 check("unstall_ready", a_ready, 2'b10);
    check("unstall_src", sa_source, 5'h0c);
    step(); drive(1, GET, 4'd2, 4'hd, 32'h800, 32'h0, 1'b0);
    #1 check("no_bubble_valid", sa_valid, 1);
    check("no_bubble_src", sa_source, 5'h1d);
    step();
    #1 check("drain_valid", sa_valid, 0);

    // D channel routing.
    sd_valid = 1'b1; sd_source = {1'b1, 4'h7}; sd_data = 32'hcafe_f00d;
    sd_opcode = 3'(ACK_DATA); d_ready = 2'b01;
    #1 check("d_backpressure", sd_ready, 0);
    d_ready = 2'b11;
    #1 check("d_ready_pass", sd_ready, 1);
    check("d_valid_route", d_valid, 2'b10);
    check("d_source_m1", d_source[7:4], 4'h7);
    check("d_data_m1", d_data[63:32], 32'hcafe_f00d);
    sd_source = {1'b0, 4'h4}; d_ready = 2'b10;
    #1 check("d_route_m0_ready", sd_ready, 0);
    check("d_route_m0_valid", d_valid, 2'b01);
    sd_valid = 1'b0; d_ready = 2'b00;

    // M=3: index 3 has no master.
    x3_sd_valid = 1'b1; x3_sd_source = {2'd3, 4'h2};
    #1 check("m3_err_ready", x3_sd_ready, 1);
    check("m3_err_no_valid", x3_d_valid, 3'b000);
    check("m3_err_before", x3_dec_err, 0);
    step(); x3_sd_valid = 1'b0;
    #1 check("m3_err_pulse", x3_dec_err, 1);
    step();
    #1 check("m3_err_clear", x3_dec_err, 0);

    // Reset in the middle of a master-1 burst.
    drive(1, PUT_FULL, 4'd4, 4'h6, 32'h900, 32'hd000_0000, 1'b1);
    #1 check("rburst_ready", a_ready, 2'b10);
    step(); drive(1, PUT_FULL, 4'd4, 4'h6, 32'h900, 32'hd000_0001, 1'b1);
    step(); drive(1, PUT_FULL, 4'd4, 4'h6, 32'h900, 32'hd000_0002, 1'b1);
    drive(0, GET, 4'd2, 4'h8, 32'ha00, 32'h0, 1'b1);
    #1 check("rburst_locked", a_ready, 2'b10);
    rst_n = 1'b0;
    #1 check("rburst_reset_valid", sa_valid, 0);
    check("rburst_reset_idle", a_ready, 2'b01);
    step(); rst_n = 1'b1;
    #1 check("post_reset_first", a_ready, 2'b01);
    a_valid = '0;

    // Random traffic: both masters stay busy, so the order is fully determined.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; mptr[m] = 0;
      for (int t = 0; t < 10; t++) begin
        int kind, nb;
        logic [2:0] op;
        logic [3:0] sz, src;
        logic [31:0] addr;
        kind = $urandom_range(0, 4);
        src  = 4'($urandom);
        addr = $urandom;
        case (kind)
          0: begin op = 3'(GET); sz = 4'd2; end
          1: begin op = 3'(PUT_PARTIAL); sz = 4'd2; end
          2: begin op = 3'(PUT_FULL); sz = 4'($urandom_range(3, 5)); end
          3: begin op = 3'(PUT_FULL); sz = 4'd13; end
          default: begin op = 3'(PUT_PARTIAL); sz = 4'($urandom_range(3, 4)); end
        endcase
        nb = (op != 3'(GET) && sz >= 3 && sz <= 12) ? (1 << sz) / 4 : 1;
        for (int b = 0; b < nb; b++) begin
          mb[m][mcnt[m]] = '{m: 1'(m), op: op, size: sz, src: src, addr: addr,
                             data: $urandom, last: (b == nb - 1)};
          mcnt[m]++;
        end
      end
    end
    begin
      int p, ptr[2];
      p = 0; ptr[0] = 0; ptr[1] = 0;
      while (ptr[0] < mcnt[0] || ptr[1] < mcnt[1]) begin
        int w;
        w = (ptr[p] < mcnt[p]) ? p : 1 - p;
        do begin
          exp_q.push_back(mb[w][ptr[w]]);
          ptr[w]++;
        end while (!mb[w][ptr[w]-1].last);
        p = 1 - w;
      end
    end
    begin
      int cycles, total;
      beat_t e;
      cycles = 0;
      total = mcnt[0] + mcnt[1];
      while (exp_q.size() > 0 && cycles < 4000) begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
          if (mptr[m] < mcnt[m])
            drive(m, mb[m][mptr[m]].op, mb[m][mptr[m]].size, mb[m][mptr[m]].src,
                  mb[m][mptr[m]].addr, mb[m][mptr[m]].data, 1'b1);
          else
            drive(m, 3'd0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        sa_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (sa_valid && sa_ready) begin
          e = exp_q.pop_front();
          check("rnd_beat", {sa_source, sa_opcode, sa_size, sa_data},
                {e.m, e.src, e.op, e.size, e.data});
          check("rnd_addr", sa_address, e.addr);
        end
        for (int m = 0; m < 2; m++)
          if (a_valid[m] && a_ready[m]) mptr[m]++;
        cycles++;
      end
      check("rnd_drained", 64'(exp_q.size()), 0);
      check("rnd_all_accepted", 64'(mptr[0] + mptr[1]), 64'(total));
      step();
      a_valid = '0; sa_ready = 1'b1;
      #1 check("rnd_final_idle", sa_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
